sqrt2_host_if: RTL and testbench

Host-side sequencer that drives one `sqrt2` unit over its shared bidirectional 16-bit data bus. It accepts an FP16 operand on a valid/ready request port and drives it onto the bus with ENABLE raised. It then releases the bus, waits for RESULT, captures the root and status flags, and returns them on a valid/ready response port. It sits directly downstream of the `sqrt2` pack/output stage and consumes everything that stage produces.

---
 rtl/sqrt2_host_if.sv | 229 ++++++++++++++++++++++
 tb/tb_sqrt2_host_if.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sqrt2_host_if.sv
// ---------------------------------------------------------------------------
// sqrt2_host_if
//
// Host-side sequencer for one sqrt2 unit sharing a bidirectional 16-bit bus.
// An FP16 operand accepted on the request port is driven onto the bus with
// ENABLE raised. The bus is then released and the block waits for RESULT.
// The root and status flags are captured and returned on the response port.
// If RESULT never arrives, a timeout response is returned instead.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   req_valid/ready : operand handshake; ready only while IDLE
//   req_data        : FP16 operand
//   rsp_valid/ready : response handshake; rsp_* held while stalled
//   rsp_data        : captured FP16 root (0 on timeout)
//   rsp_nan/pinf/ninf : captured sqrt2 status flags
//   rsp_timeout     : RESULT not seen within TIMEOUT WAIT cycles
//   rsp_latency     : cycles from ENABLE rise to RESULT seen (saturating)
//   sqrt_io         : shared bus to sqrt2 IO_DATA
//   sqrt_enable     : ENABLE to sqrt2 (low also resets sqrt2)
//   sqrt_result, sqrt_is_nan, sqrt_is_pinf, sqrt_is_ninf : from sqrt2
//   busy            : high in every state except IDLE
// ---------------------------------------------------------------------------
module sqrt2_host_if #(
  parameter int DRIVE_CYCLES = 1,   // 1..15
  parameter int TIMEOUT      = 64,  // 2..2^CNT_W-1
  parameter int GAP_CYCLES   = 2,   // >= 1
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_nan,
  output logic             rsp_pinf,
  output logic             rsp_ninf,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] rsp_latency,
  inout  wire  [15:0]      sqrt_io,
  output logic             sqrt_enable,
  input  logic             sqrt_result,
  input  logic             sqrt_is_nan,
  input  logic             sqrt_is_pinf,
  input  logic             sqrt_is_ninf,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Gap counter needs to hold GAP_CYCLES itself (it saturates there).
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

  localparam logic [3:0]       DRIVE_LAST   = 4'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LAT_MAX      = '1;
  localparam logic [GW-1:0]    GAP_TGT      = GW'(GAP_CYCLES);

  state_t           state_q;
  logic [15:0]      drv_q;
  logic             drv_en_q;
  logic [3:0]       drv_cnt_q;
  logic [CNT_W-1:0] lat_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [GW-1:0]    gap_cnt_q;

  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_data_q;
  logic             rsp_nan_q;
  logic             rsp_pinf_q;
  logic             rsp_ninf_q;
  logic             rsp_timeout_q;
  logic [CNT_W-1:0] rsp_latency_q;
  logic             sqrt_enable_q;
  logic             busy_q;

  // Next-value helpers for the saturating counters.
  logic [CNT_W-1:0] lat_d;
  logic [GW-1:0]    gap_cnt_d;
  logic             gap_done;

  always_comb begin
    lat_d     = (lat_q == LAT_MAX) ? lat_q : lat_q + CNT_W'(1);
    gap_cnt_d = (gap_cnt_q >= GAP_TGT) ? gap_cnt_q : gap_cnt_q + GW'(1);
    // gap_cnt_q counts low-ENABLE cycles including the current one.
    gap_done  = (gap_cnt_q >= GAP_TGT);
  end

  // The bus driver enable is a flop, so the pin never glitches between
  // host drive and release.
  assign sqrt_io = drv_en_q ? drv_q : 16'hzzzz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      drv_q         <= '0;
      drv_en_q      <= 1'b0;
      drv_cnt_q     <= '0;
      lat_q         <= '0;
      wait_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_nan_q     <= 1'b0;
      rsp_pinf_q    <= 1'b0;
      rsp_ninf_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_latency_q <= '0;
      sqrt_enable_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            drv_q         <= req_data;
            drv_en_q      <= 1'b1;
            sqrt_enable_q <= 1'b1;
            lat_q         <= '0;
            drv_cnt_q     <= '0;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= ST_DRIVE;
          end else begin
            // Also raises ready on the first cycle after reset.
            req_ready_q <= 1'b1;
          end
        end

        ST_DRIVE: begin
          lat_q <= lat_d;
          if (drv_cnt_q == DRIVE_LAST) begin
            drv_en_q   <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT;
          end else begin
            drv_cnt_q <= drv_cnt_q + 4'd1;
          end
        end

        ST_WAIT: begin
          lat_q <= lat_d;
          // RESULT has priority, so a result on the expiring cycle wins.
          if (sqrt_result) begin
            rsp_data_q    <= sqrt_io;
            rsp_nan_q     <= sqrt_is_nan;
            rsp_pinf_q    <= sqrt_is_pinf;
            rsp_ninf_q    <= sqrt_is_ninf;
            rsp_timeout_q <= 1'b0;
            rsp_latency_q <= lat_d;
            rsp_valid_q   <= 1'b1;
            sqrt_enable_q <= 1'b0;
            gap_cnt_q     <= GW'(1);
            state_q       <= ST_RESP;
          end else if (wait_cnt_q == TIMEOUT_LAST) begin
            rsp_data_q    <= '0;
            rsp_nan_q     <= 1'b0;
            rsp_pinf_q    <= 1'b0;
            rsp_ninf_q    <= 1'b0;
            rsp_timeout_q <= 1'b1;
            rsp_latency_q <= lat_d;
            rsp_valid_q   <= 1'b1;
            sqrt_enable_q <= 1'b0;
            gap_cnt_q     <= GW'(1);
            state_q       <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end

        ST_RESP: begin
          // ENABLE is already low here, so these cycles count toward the gap.
          gap_cnt_q <= gap_cnt_d;
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (gap_done) begin
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              state_q <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (gap_done) begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end

        default: begin
          drv_en_q      <= 1'b0;
          sqrt_enable_q <= 1'b0;
          rsp_valid_q   <= 1'b0;
          req_ready_q   <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_nan     = rsp_nan_q;
  assign rsp_pinf    = rsp_pinf_q;
  assign rsp_ninf    = rsp_ninf_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_latency = rsp_latency_q;
  assign sqrt_enable = sqrt_enable_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sqrt2_host_if.sv
module tb_sqrt2_host_if;

  localparam int DC  = 1;
  localparam int TO  = 64;
  localparam int GAP = 2;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [15:0]   req_data = 16'h0000;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [15:0]   rsp_data;
  logic          rsp_nan, rsp_pinf, rsp_ninf, rsp_timeout;
  logic [CW-1:0] rsp_latency;
  wire  [15:0]   sqrt_io;
  logic          sqrt_enable;
  logic          sqrt_result, sqrt_is_nan, sqrt_is_pinf, sqrt_is_ninf;
  logic          busy;

  always #5 clk = ~clk;

  sqrt2_host_if #(
    .DRIVE_CYCLES(DC), .TIMEOUT(TO), .GAP_CYCLES(GAP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_nan(rsp_nan), .rsp_pinf(rsp_pinf), .rsp_ninf(rsp_ninf),
    .rsp_timeout(rsp_timeout), .rsp_latency(rsp_latency),
    .sqrt_io(sqrt_io), .sqrt_enable(sqrt_enable), .sqrt_result(sqrt_result),
    .sqrt_is_nan(sqrt_is_nan), .sqrt_is_pinf(sqrt_is_pinf),
    .sqrt_is_ninf(sqrt_is_ninf), .busy(busy)
  );

  // sqrt2 model: m_cnt is the number of ENABLE-high cycles before the
  // current one, so RESULT first appears in the m_delay-th ENABLE-high cycle.
  // From the 4th ENABLE cycle it drives intermediate junk onto the bus.
  int          m_cnt   = 0;
  int          m_delay = 5;
  bit          m_never = 1'b0;
  logic [15:0] m_res   = 16'h0000;
  logic [2:0]  m_fl    = 3'b000;

  always @(posedge clk) m_cnt <= sqrt_enable ? m_cnt + 1 : 0;

  wire        m_result = sqrt_enable && !m_never && (m_cnt >= m_delay - 1);
  wire        m_drive  = sqrt_enable && (m_cnt >= 3);
  wire [15:0] m_bus    = m_result ? m_res : (16'hA5A5 ^ 16'(m_cnt));

  assign sqrt_io      = m_drive ? m_bus : 16'hzzzz;
  assign sqrt_result  = m_result;
  assign sqrt_is_nan  = m_result ? m_fl[2] : m_cnt[0];
  assign sqrt_is_pinf = m_result ? m_fl[1] : m_cnt[1];
  assign sqrt_is_ninf = m_result ? m_fl[0] : m_cnt[2];

  int contention = 0;
  always @(negedge clk) if (m_drive && dut.drv_en_q) contention <= contention + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] op, input int dly, input logic [15:0] res,
                        input logic [2:0] fl, input bit never, input int bp);
    int          idx;
    bit          to;
    logic [27:0] held;
    to = never || (dly > DC + TO);
    m_delay = dly; m_res = res; m_fl = fl; m_never = never;
    wait_ready();
    req_valid = 1'b1; req_data = op;
    step();
    req_valid = 1'b0;
    chk("enable_rise", 32'(sqrt_enable), 32'd1);
    chk("drive_val", 32'(sqrt_io), 32'(op));
    chk("busy_op", 32'(busy), 32'd1);
    for (int i = 0; i < DC; i++) step();
    chk("bus_release", 32'(dut.drv_en_q), 32'd0);
    chk("enable_hold", 32'(sqrt_enable), 32'd1);
    idx = DC + 1;
    while (!rsp_valid && idx < 300) begin
      step();
      idx++;
    end
    chk("rsp_cycle", 32'(idx), to ? 32'(DC + TO + 1) : 32'(dly + 1));
    chk("rsp_data", 32'(rsp_data), to ? 32'd0 : 32'(res));
    chk("rsp_flags", 32'({rsp_nan, rsp_pinf, rsp_ninf}), to ? 32'd0 : 32'(fl));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(to));
    if (!to) chk("rsp_latency", 32'(rsp_latency), 32'(dly));
    chk("enable_drop", 32'(sqrt_enable), 32'd0);
    held = {rsp_data, rsp_nan, rsp_pinf, rsp_ninf, rsp_timeout, rsp_latency};
    // A second request waits throughout the response and gap.
    req_valid = 1'b1; req_data = 16'h1234;
    for (int i = 0; i < bp; i++) begin
      step();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp", 32'({rsp_data, rsp_nan, rsp_pinf, rsp_ninf, rsp_timeout, rsp_latency}),
          32'(held));
      chk("req_blocked", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_clear", 32'(rsp_valid), 32'd0);
    if (bp == 0) begin
      chk("gap_ready", 32'(req_ready), 32'd0);
      chk("gap_enable", 32'(sqrt_enable), 32'd0);
      step();
    end
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_enable", 32'(sqrt_enable), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    req_valid = 1'b0;
    $display("op %04h dly %0d bp %0d -> data %04h flags %b timeout %0b latency %0d",
             op, dly, bp, held[27:12], held[11:9], held[8], held[7:0]);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_enable", 32'(sqrt_enable), 32'd0);
    chk("rst_drv_en", 32'(dut.drv_en_q), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp", 32'({rsp_data, rsp_nan, rsp_pinf, rsp_ninf, rsp_timeout, rsp_latency}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    run_op(16'h4400, 5, 16'h4000, 3'b000, 1'b0, 0);   // sqrt(4.0) = 2.0
    run_op(16'hBC00, 6, 16'h7E00, 3'b100, 1'b0, 1);   // sqrt(-1.0) = NaN
    run_op(16'h7C00, 4, 16'h7C00, 3'b010, 1'b0, 2);   // +inf
    run_op(16'h0000, 8, 16'h0000, 3'b000, 1'b1, 0);   // no RESULT -> timeout
    run_op(16'h4400, 65, 16'h4000, 3'b000, 1'b0, 0);  // RESULT on expiring cycle
    run_op(16'h4400, 7, 16'h4000, 3'b000, 1'b0, 10);  // backpressure

    // Reset while waiting for a RESULT that never comes.
    m_never = 1'b1;
    wait_ready();
    req_valid = 1'b1; req_data = 16'h5555;
    step();
    req_valid = 1'b0;
    repeat (10) step();
    chk("mid_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_enable", 32'(sqrt_enable), 32'd0);
    chk("mrst_drv_en", 32'(dut.drv_en_q), 32'd0);
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    $display("reset applied mid-WAIT");
    run_op(16'h3C00, 5, 16'h3C00, 3'b000, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      run_op(16'($urandom), int'($urandom_range(4, 20)), 16'($urandom),
             3'($urandom_range(0, 7)), 1'b0, int'($urandom_range(0, 3)));
    end
    chk("contention", 32'(contention), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
